// File: rtl/obi_mem_responder.sv
// Responder end of a req/gnt/r_valid bus in front of a 1-cycle-latency SRAM.
// Fixed-latency responses, out-of-range error flag, quiesce/drain handshake.
module obi_mem_responder #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned MemWords       = 1024,
  parameter int unsigned RespLatency    = 2,
  parameter int unsigned NumOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        quiesce_i,
  output logic                        quiesced_o,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [AW-1:0]               addr_i,
  input  logic [DW-1:0]               data_i,
  input  logic [DW/8-1:0]             be_i,
  output logic                        r_valid_o,
  output logic                        r_err_o,
  output logic [DW-1:0]               r_rdata_o,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  output logic                        mem_we_o,
  output logic [$clog2(MemWords)-1:0] mem_addr_o,
  output logic [DW-1:0]               mem_wdata_o,
  output logic [DW/8-1:0]             mem_be_o,
  input  logic [DW-1:0]               mem_rdata_i
);

  localparam int unsigned BeW   = DW / 8;
  localparam int unsigned OffW  = $clog2(BeW);
  localparam int unsigned MemAW = $clog2(MemWords);
  localparam int unsigned CntW  = $clog2(NumOutstanding + 1);
  localparam logic [63:0] MemBytes = 64'(MemWords) * 64'(BeW);

  typedef enum logic [1:0] {StActive, StDrain, StQuiesced} state_e;

  state_e                 state_q, state_d;
  logic                   quiesced_q;
  logic [CntW-1:0]        cnt_q, cnt_d, cnt_avail;
  logic [RespLatency-1:0] vld_q, err_q, we_q;
  logic                   in_range, admit, accept, retire, rd_ok;
  logic [DW-1:0]          rdata_c;

  assign in_range  = 64'(addr_i) < MemBytes;
  assign retire    = vld_q[RespLatency-1];
  // A slot freed by this cycle's retire can be reused in the same cycle.
  assign cnt_avail = cnt_q - CntW'(retire);
  assign accept    = req_i & gnt_o;

  // FSM state register (also holds the registered quiesced flag)
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StActive;
      quiesced_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      quiesced_q <= (state_d == StQuiesced);
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StActive:   if (quiesce_i) state_d = StDrain;
      StDrain: begin
        if (!quiesce_i)          state_d = StActive;
        else if (cnt_d == '0)    state_d = StQuiesced;
      end
      StQuiesced: if (!quiesce_i) state_d = StActive;
      default:    state_d = StActive;
    endcase
  end

  // FSM outputs: admission, grant and SRAM strobe
  always_comb begin
    admit     = rst_ni & (state_q == StActive) & ~quiesce_i
              & (cnt_avail < CntW'(NumOutstanding));
    gnt_o     = req_i & admit & (mem_gnt_i | ~in_range);
    mem_req_o = req_i & admit & in_range & mem_gnt_i;
  end

  assign mem_we_o    = we_i;
  assign mem_wdata_o = data_i;
  assign mem_be_o    = be_i;
  assign mem_addr_o  = addr_i[OffW +: MemAW];

  always_comb begin
    cnt_d = cnt_q + CntW'(accept) - CntW'(retire);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Response control pipeline: stage 0 is loaded on accept
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      we_q  <= '0;
    end else begin
      vld_q[0] <= accept;
      err_q[0] <= accept & ~in_range;
      we_q[0]  <= accept & we_i;
      for (int unsigned i = 1; i < RespLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        we_q[i]  <= we_q[i-1];
      end
    end
  end

  assign rd_ok = vld_q[0] & ~err_q[0] & ~we_q[0];

  if (RespLatency == 1) begin : g_lat1
    assign rdata_c = rd_ok ? mem_rdata_i : '0;
  end else begin : g_latn
    logic [DW-1:0] rdata_q [RespLatency-1];

    // SRAM data arrives while the entry sits in stage 0; capture it there
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rdata_q <= '{default: '0};
      end else begin
        rdata_q[0] <= rd_ok ? mem_rdata_i : '0;
        for (int unsigned k = 1; k < RespLatency - 1; k++) begin
          rdata_q[k] <= rdata_q[k-1];
        end
      end
    end

    assign rdata_c = rdata_q[RespLatency-2];
  end

  assign r_valid_o  = rst_ni & retire;
  assign r_err_o    = r_valid_o & err_q[RespLatency-1];
  assign r_rdata_o  = r_valid_o ? rdata_c : '0;
  assign quiesced_o = rst_ni & quiesced_q;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder: default instance (lat 2, 2 outstanding)
// plus a throttled instance (lat 3, 1 outstanding), each with its own SRAM model.
module tb_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        quiesce;
  logic        req_a, req_b;
  logic        we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        mem_gnt;

  logic        quiesced_a, gnt_a, r_valid_a, r_err_a, mreq_a, mwe_a;
  logic [31:0] r_rdata_a, mwdata_a, mrdata_a;
  logic [9:0]  maddr_a;
  logic [3:0]  mbe_a;

  logic        quiesced_b, gnt_b, r_valid_b, r_err_b, mreq_b, mwe_b;
  logic [31:0] r_rdata_b, mwdata_b, mrdata_b;
  logic [9:0]  maddr_b;
  logic [3:0]  mbe_b;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  obi_mem_responder #(.AW(32), .DW(32), .MemWords(1024), .RespLatency(2), .NumOutstanding(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .quiesce_i(quiesce), .quiesced_o(quiesced_a),
    .req_i(req_a), .gnt_o(gnt_a), .we_i(we), .addr_i(addr), .data_i(wdata), .be_i(be),
    .r_valid_o(r_valid_a), .r_err_o(r_err_a), .r_rdata_o(r_rdata_a),
    .mem_req_o(mreq_a), .mem_gnt_i(mem_gnt), .mem_we_o(mwe_a), .mem_addr_o(maddr_a),
    .mem_wdata_o(mwdata_a), .mem_be_o(mbe_a), .mem_rdata_i(mrdata_a)
  );

  obi_mem_responder #(.AW(32), .DW(32), .MemWords(1024), .RespLatency(3), .NumOutstanding(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .quiesce_i(quiesce), .quiesced_o(quiesced_b),
    .req_i(req_b), .gnt_o(gnt_b), .we_i(we), .addr_i(addr), .data_i(wdata), .be_i(be),
    .r_valid_o(r_valid_b), .r_err_o(r_err_b), .r_rdata_o(r_rdata_b),
    .mem_req_o(mreq_b), .mem_gnt_i(mem_gnt), .mem_we_o(mwe_b), .mem_addr_o(maddr_b),
    .mem_wdata_o(mwdata_b), .mem_be_o(mbe_b), .mem_rdata_i(mrdata_b)
  );

  // Single-port SRAM models, 1-cycle read latency
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];

  always @(posedge clk) begin
    if (mreq_a) begin
      if (mwe_a) begin
        for (int b = 0; b < 4; b++) if (mbe_a[b]) mem_a[maddr_a][8*b +: 8] <= mwdata_a[8*b +: 8];
      end else begin
        mrdata_a <= mem_a[maddr_a];
      end
    end
  end

  always @(posedge clk) begin
    if (mreq_b) begin
      if (mwe_b) begin
        for (int b = 0; b < 4; b++) if (mbe_b[b]) mem_b[maddr_b][8*b +: 8] <= mwdata_b[8*b +: 8];
      end else begin
        mrdata_b <= mem_b[maddr_b];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req_a(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b);
    req_a = r; we = w; addr = a; wdata = d; be = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; quiesce = 1'b0; req_a = 1'b0; req_b = 1'b0;
    we = 1'b0; addr = '0; wdata = '0; be = '0; mem_gnt = 1'b1;

    // Reset cycle: request present but nothing may be granted
    tick(); set_req_a(1, 0, 32'h10, 0, 4'hF); #1;
    check("rst_gnt", gnt_a, 0);
    check("rst_memreq", mreq_a, 0);
    check("rst_rvalid", r_valid_a, 0);
    check("rst_quiesced", quiesced_a, 0);
    tick(); rst_n = 1'b1; req_a = 1'b0; #1;
    check("post_rst_rvalid", r_valid_a, 0);

    // Write 0x10 then read it back
    tick(); set_req_a(1, 1, 32'h10, 32'hDEADBEEF, 4'hF); #1;
    check("wr_gnt", gnt_a, 1);
    check("wr_memreq", mreq_a, 1);
    check("wr_memaddr", maddr_a, 4);
    check("wr_memwe", mwe_a, 1);
    tick(); set_req_a(1, 0, 32'h10, 0, 4'hF); #1;
    check("rd_gnt", gnt_a, 1);
    check("rd_no_early_rvalid", r_valid_a, 0);
    tick(); req_a = 1'b0; #1;
    check("wr_rvalid", r_valid_a, 1);
    check("wr_rdata", r_rdata_a, 0);
    check("wr_rerr", r_err_a, 0);
    tick(); #1;
    check("rd_rvalid", r_valid_a, 1);
    check("rd_rdata", r_rdata_a, 32'hDEADBEEF);
    check("rd_rerr", r_err_a, 0);
    tick(); #1;
    check("idle_rvalid", r_valid_a, 0);
    check("idle_rdata", r_rdata_a, 0);

    // Out-of-range read needs no SRAM grant
    tick(); set_req_a(1, 0, 32'h1000, 0, 4'hF); mem_gnt = 1'b0; #1;
    check("oor_gnt", gnt_a, 1);
    check("oor_memreq", mreq_a, 0);
    tick(); req_a = 1'b0; mem_gnt = 1'b1; #1;
    check("oor_no_early_rvalid", r_valid_a, 0);
    tick(); #1;
    check("oor_rvalid", r_valid_a, 1);
    check("oor_rerr", r_err_a, 1);
    check("oor_rdata", r_rdata_a, 0);
    tick(); #1;
    check("oor_rerr_clear", r_err_a, 0);

    // SRAM stall on the last in-range word
    for (int i = 0; i < 3; i++) begin
      tick(); set_req_a(1, 1, 32'hFFC, 32'h12345678, 4'hF); mem_gnt = 1'b0; #1;
      check("stall_gnt", gnt_a, 0);
      check("stall_memreq", mreq_a, 0);
      check("stall_rvalid", r_valid_a, 0);
    end
    tick(); mem_gnt = 1'b1; #1;
    check("unstall_gnt", gnt_a, 1);
    check("unstall_memreq", mreq_a, 1);
    check("unstall_memaddr", maddr_a, 10'h3FF);
    tick(); set_req_a(1, 1, 32'hFFC, 32'h000000AB, 4'h1); #1;
    check("pwr_gnt", gnt_a, 1);
    check("pwr_membe", mbe_a, 4'h1);
    tick(); req_a = 1'b0; #1;
    check("stall_wr_rvalid", r_valid_a, 1);
    tick(); #1;
    check("pwr_rvalid", r_valid_a, 1);
    tick(); #1;
    check("pwr_idle", r_valid_a, 0);

    // Quiesce with two reads in flight
    tick(); set_req_a(1, 0, 32'h10, 0, 4'hF); #1;
    check("q_rd0_gnt", gnt_a, 1);
    tick(); addr = 32'hFFC; #1;
    check("q_rd1_gnt", gnt_a, 1);
    tick(); addr = 32'h10; quiesce = 1'b1; #1;
    check("q_rise_gnt", gnt_a, 0);
    check("q_rise_rvalid", r_valid_a, 1);
    check("q_rise_rdata", r_rdata_a, 32'hDEADBEEF);
    check("q_rise_quiesced", quiesced_a, 0);
    tick(); #1;
    check("q_drain_gnt", gnt_a, 0);
    check("q_drain_rvalid", r_valid_a, 1);
    check("q_drain_rdata", r_rdata_a, 32'h123456AB);
    check("q_drain_quiesced", quiesced_a, 0);
    tick(); #1;
    check("q_done_quiesced", quiesced_a, 1);
    check("q_done_gnt", gnt_a, 0);
    check("q_done_memreq", mreq_a, 0);
    check("q_done_rvalid", r_valid_a, 0);
    tick(); #1;
    check("q_hold_quiesced", quiesced_a, 1);
    tick(); quiesce = 1'b0; #1;
    check("q_drop_gnt", gnt_a, 0);
    check("q_drop_quiesced", quiesced_a, 1);
    tick(); #1;
    check("q_resume_gnt", gnt_a, 1);
    check("q_resume_quiesced", quiesced_a, 0);
    tick(); req_a = 1'b0; #1;
    check("q_resume_wait", r_valid_a, 0);
    tick(); #1;
    check("q_resume_rdata", r_rdata_a, 32'hDEADBEEF);

    // Quiesce from idle: quiesced two cycles after the rise
    tick(); quiesce = 1'b1; #1;
    check("qi_r0", quiesced_a, 0);
    tick(); #1;
    check("qi_r1", quiesced_a, 0);
    tick(); #1;
    check("qi_r2", quiesced_a, 1);
    tick(); quiesce = 1'b0; #1;
    check("qi_drop", quiesced_a, 1);
    tick(); #1;
    check("qi_active", quiesced_a, 0);

    // Reset with two responses pending
    tick(); set_req_a(1, 0, 32'h10, 0, 4'hF); #1;
    check("mr_rd0_gnt", gnt_a, 1);
    tick(); addr = 32'hFFC; #1;
    check("mr_rd1_gnt", gnt_a, 1);
    tick(); req_a = 1'b0; rst_n = 1'b0; #1;
    check("mr_rst_rvalid", r_valid_a, 0);
    check("mr_rst_quiesced", quiesced_a, 0);
    tick(); rst_n = 1'b1; #1;
    check("mr_post_rvalid", r_valid_a, 0);
    check("mr_post_quiesced", quiesced_a, 0);
    tick(); set_req_a(1, 0, 32'h10, 0, 4'hF); #1;
    check("mr_dropped_rvalid", r_valid_a, 0);
    check("mr_b2b0_gnt", gnt_a, 1);
    tick(); addr = 32'hFFC; #1;
    check("mr_b2b1_gnt", gnt_a, 1);
    tick(); addr = 32'h10; #1;
    check("mr_b2b2_gnt", gnt_a, 1);
    check("mr_b2b0_rdata", r_rdata_a, 32'hDEADBEEF);
    tick(); req_a = 1'b0; #1;
    check("mr_b2b1_rdata", r_rdata_a, 32'h123456AB);
    tick(); #1;
    check("mr_b2b2_rdata", r_rdata_a, 32'hDEADBEEF);
    tick(); #1;
    check("mr_idle", r_valid_a, 0);

    // Throttled instance: seed word, then 4 back-to-back reads
    tick(); req_b = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hCAFEF00D; be = 4'hF; #1;
    check("th_wr_gnt", gnt_b, 1);
    tick(); req_b = 1'b0; we = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    check("th_wr_rvalid", r_valid_b, 1);
    for (int i = 0; i < 13; i++) begin
      tick(); req_b = (i < 10); we = 1'b0; addr = 32'h10; #1;
      check("th_gnt", gnt_b, (i < 10) && (i % 3 == 0));
      check("th_rvalid", r_valid_b, (i >= 3) && (i % 3 == 0));
      if ((i >= 3) && (i % 3 == 0)) check("th_rdata", r_rdata_b, 32'hCAFEF00D);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
